// File: rtl/dff_write_arbiter.sv
// -----------------------------------------------------------------------------
// dff_write_arbiter
//
// Purpose:
//    Shares one WIDTH-bit rising-edge register between N_REQ requesters.
//    A round-robin state machine grants the register to one requester at a
//    time. Every granted cycle in which the owner still requests writes the
//    owner's data into the register. A grant lasts at most HOLD_MAX writes.
//    When a grant ends, the next requester takes over on the following edge,
//    with no idle cycle between grants.
//
// Ports:
//    clk       in   1            clock; all state updates on posedge
//    reset     in   1            synchronous, active-high reset
//    req       in   N_REQ        level request, one bit per requester
//    d_bus     in   N_REQ*WIDTH  requester i data at d_bus[i*WIDTH +: WIDTH]
//    gnt       out  N_REQ        registered one-hot grant; zero when idle
//    q         out  WIDTH        shared register contents
//    q_update  out  1            high while q shows a freshly written value
//
// Configuration macro:
//    DFF_ARB_PRIO0_EN  when defined, every pick returns requester 0 whenever
//                      req[0] is high. Otherwise the pick is pure round-robin.
// -----------------------------------------------------------------------------
module dff_write_arbiter #(
   parameter int N_REQ    = 4,
   parameter int WIDTH    = 1,
   parameter int HOLD_MAX = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] d_bus,
   output logic [N_REQ-1:0]       gnt,
   output logic [WIDTH-1:0]       q,
   output logic                   q_update
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(HOLD_MAX + 1);

   typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic               q_update_q, q_update_d;

   logic [WIDTH-1:0]   d_lane [N_REQ];
   logic [N_REQ-1:0]   hi_req;
   logic [N_REQ-1:0]   pick_src;
   logic [IDX_W-1:0]   pick_base;
   logic [IDX_W-1:0]   pick_idx;
   logic               wr_en;
   logic               release_now;

   // Per-requester data lanes and the "strictly above the scan base" mask.
   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_lane
         assign d_lane[gi] = d_bus[gi*WIDTH +: WIDTH];
         assign hi_req[gi] = req[gi] & (IDX_W'(gi) > pick_base);
      end
   endgenerate

   // While granted, the current owner becomes "last" at release, so the
   // scan base is the owner itself. In IDLE it is the last released owner.
   assign pick_base = (state_q == S_GRANT) ? owner_q : last_q;

   // Round-robin pick. Requesters above the base win first. If none of those
   // requests, the scan wraps to the lowest requester, which may be the base
   // itself. This wrap is how a sole requester gets re-picked.
   always_comb begin
      pick_src = (|hi_req) ? hi_req : req;
      pick_idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (pick_src[i]) pick_idx = IDX_W'(i);
      end
`ifdef DFF_ARB_PRIO0_EN
      if (req[0]) pick_idx = '0;
`else
`endif
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         owner_q    <= '0;
         last_q     <= IDX_W'(N_REQ - 1);
         hold_cnt_q <= '0;
         gnt_q      <= '0;
         q_q        <= '0;
         q_update_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         hold_cnt_q <= hold_cnt_d;
         gnt_q      <= gnt_d;
         q_q        <= q_d;
         q_update_q <= q_update_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      hold_cnt_d  = hold_cnt_q;
      gnt_d       = gnt_q;
      release_now = 1'b0;
      case (state_q)
         S_IDLE: begin
            gnt_d = '0;
            if (|req) begin
               state_d    = S_GRANT;
               owner_d    = pick_idx;
               gnt_d      = N_REQ'(1) << pick_idx;
               hold_cnt_d = '0;
            end
         end
         S_GRANT: begin
            // A dropped request ends the grant without a write. Reaching the
            // hold limit ends it after this cycle's write.
            release_now = !req[owner_q] || (hold_cnt_q == CNT_W'(HOLD_MAX - 1));
            if (req[owner_q]) hold_cnt_d = hold_cnt_q + CNT_W'(1);
            if (release_now) begin
               last_d     = owner_q;
               hold_cnt_d = '0;
               if (|req) begin
                  owner_d = pick_idx;
                  gnt_d   = N_REQ'(1) << pick_idx;
               end else begin
                  state_d = S_IDLE;
                  gnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // Output logic: write strobe and the data path into the shared register.
   always_comb begin
      wr_en      = (state_q == S_GRANT) && req[owner_q];
      q_d        = wr_en ? d_lane[owner_q] : q_q;
      q_update_d = wr_en;
   end

   assign gnt      = gnt_q;
   assign q        = q_q;
   assign q_update = q_update_q;

endmodule

// File: tb/tb_dff_write_arbiter.sv
module tb_dff_write_arbiter;

   localparam int N_REQ    = 4;
   localparam int WIDTH    = 1;
   localparam int HOLD_MAX = 4;

   logic             clk;
   logic             reset;
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] d_bus;
   logic [N_REQ-1:0] gnt;
   logic             q;
   logic             q_update;

   typedef struct {
      logic [3:0] gnt;
      logic       q;
      logic       upd;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   stim_done = 0;

   dff_write_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .d_bus    (d_bus),
      .gnt      (gnt),
      .q        (q),
      .q_update (q_update)
   );

   initial clk = 1'b0;
   always #40 clk = ~clk;

   // Drive inputs for one edge and queue the outputs expected after it.
   task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] d,
                       input logic [3:0] eg, input logic eq, input logic eu,
                       input string nm);
      exp_t e;
      reset = r;
      req   = rq;
      d_bus = d;
      e.gnt = eg; e.q = eq; e.upd = eu; e.name = nm;
      sb.push_back(e);
      @(posedge clk);
      #5;
   endtask

   // Monitor: after every edge, pop the expectation queued for it and compare.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (gnt === e.gnt && q === e.q && q_update === e.upd) begin
               n_pass++;
               $display("ok   %s: gnt=%b q=%b q_update=%b", e.name, gnt, q, q_update);
            end else begin
               $display("FAIL %s: got gnt=%b q=%b q_update=%b, want gnt=%b q=%b q_update=%b",
                        e.name, gnt, q, q_update, e.gnt, e.q, e.upd);
            end
         end
      end
   end

   initial begin
      logic [3:0] d3;
      int         own, prev;
      reset = 1'b1;
      req   = '0;
      d_bus = '0;
      #10;

      // 1. reset held with no requests
      for (int i = 0; i < 3; i++) step(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, "reset");

      // 2. single requester 0
      step(0, 4'b0001, 4'b0001, 4'b0001, 0, 0, "single_grant");
      step(0, 4'b0001, 4'b0001, 4'b0001, 1, 1, "single_write");
      step(0, 4'b0000, 4'b0001, 4'b0000, 1, 0, "single_release");
      step(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, "single_idle_hold");

      // 3. all requesting, re-reset so the scan starts at requester 0
      step(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, "rr_reset");
      d3 = 4'b1010;
      step(0, 4'b1111, d3, 4'b0001, 0, 0, "rr_first_grant");
      for (int k = 2; k <= 18; k++) begin
`ifdef DFF_ARB_PRIO0_EN
         own  = 0;
         prev = 0;
`else
         own  = ((k - 1) / HOLD_MAX) % N_REQ;
         prev = ((k - 2) / HOLD_MAX) % N_REQ;
`endif
         step(0, 4'b1111, d3, 4'(1 << own), d3[prev], 1, $sformatf("rr_edge%0d", k));
      end
      step(0, 4'b0000, d3, 4'b0000, 0, 0, "rr_drop");

      // 4. hold limit with toggling data; req[3] rises mid-grant
      step(0, 4'b0100, 4'b0000, 4'b0100, 0, 0, "hold_grant");
      step(0, 4'b0100, 4'b0100, 4'b0100, 1, 1, "hold_w1");
      step(0, 4'b1100, 4'b0000, 4'b0100, 0, 1, "hold_w2");
      step(0, 4'b1100, 4'b0100, 4'b0100, 1, 1, "hold_w3");
      step(0, 4'b1100, 4'b0000, 4'b1000, 0, 1, "hold_w4_handoff");
      step(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, "hold_release");

      // 5. reset in the middle of a grant
      step(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, "mid_pre_reset");
      step(0, 4'b0010, 4'b0010, 4'b0010, 0, 0, "mid_grant");
      step(0, 4'b0010, 4'b0010, 4'b0010, 1, 1, "mid_write");
      step(1, 4'b0010, 4'b0010, 4'b0000, 0, 0, "mid_reset_abort");
      step(0, 4'b1111, 4'b0000, 4'b0001, 0, 0, "mid_first_after_reset");
      step(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, "mid_release");

      stim_done = 1;
   end

   // Final drain check and summary, bounded by a cycle budget.
   initial begin
      int budget;
      budget = 0;
      while (!stim_done && budget < 2000) begin
         @(posedge clk);
         budget++;
      end
      #10;
      n_checks++;
      if (!stim_done || sb.size() != 0)
         $display("FAIL drain: done=%0d pending=%0d, want done=1 pending=0",
                  stim_done, sb.size());
      else
         n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
